// File: rtl/axrm_sweep_checker.sv
// Exhaustive 8x8 multiplier sweep checker: drives all 65536 operand pairs and accumulates error statistics.
// Optional max-error tracking is enabled by defining AXRM_MAXED_EN.
module axrm_sweep_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  a_out,
    output logic [7:0]  b_out,
    input  logic [15:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [16:0] err_count,
    output logic [31:0] sum_ed,
    output logic [15:0] max_ed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        launch;

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;

    logic [15:0] exact_q, exact_d;
    logic [15:0] y_q, y_d;
    logic        valid_q, valid_d;

    logic [15:0] ed;
    logic [16:0] err_q, err_d;
    logic [31:0] sum_q, sum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == 16'hFFFF) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // The operand registers always hold the pair indexed by cnt_q while in RUN,
    // so the sweep starts presenting pair 0 on the cycle right after start.
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        exact_d = {8'd0, a_q} * {8'd0, b_q};
        y_d     = y_in;
        valid_d = (state_q == RUN);
        if (launch) begin
            cnt_d   = 16'd0;
            a_d     = 8'd0;
            b_d     = 8'd0;
            valid_d = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_inc;
            if (cnt_q != 16'hFFFF) begin
                a_d = cnt_inc[15:8];
                b_d = cnt_inc[7:0];
            end
        end
    end

    assign ed = (y_q >= exact_q) ? (y_q - exact_q) : (exact_q - y_q);

    always_comb begin
        err_d = err_q;
        sum_d = sum_q;
        if (launch) begin
            err_d = 17'd0;
            sum_d = 32'd0;
        end else if (valid_q) begin
            err_d = err_q + {16'd0, (ed != 16'd0)};
            sum_d = sum_q + {16'd0, ed};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 16'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            exact_q <= 16'd0;
            y_q     <= 16'd0;
            valid_q <= 1'b0;
            err_q   <= 17'd0;
            sum_q   <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exact_q <= exact_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

`ifdef AXRM_MAXED_EN
    logic [15:0] max_q, max_d;

    // Strict compare: an equal error leaves the stored maximum untouched.
    always_comb begin
        max_d = max_q;
        if (launch) begin
            max_d = 16'd0;
        end else if (valid_q && (ed > max_q)) begin
            max_d = ed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= 16'd0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_ed = max_q;
`else
    assign max_ed = 16'd0;
`endif

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign err_count = err_q;
    assign sum_ed    = sum_q;

endmodule

// File: tb/tb_axrm_sweep_checker.sv
// Scoreboard bench for axrm_sweep_checker: a mixed-error multiplier model drives y_in,
// expected sweep statistics are queued at start and compared when done rises.
module tb_axrm_sweep_checker;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [15:0] y_in;
    logic        busy;
    logic        done;
    logic [16:0] err_count;
    logic [31:0] sum_ed;
    logic [15:0] max_ed;

    logic        zero_mode = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb_q[$];

    int          pair_idx = 0;
    int          pair_err = 0;
    int          busy_cnt = 0;
    int          last_busy_len = 0;
    logic        busy_prev = 1'b0;

    axrm_sweep_checker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_out     (a_out),
        .b_out     (b_out),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier under test: exact, stuck-at-zero, LSB-flipped or small additive noise by operand quadrant.
    function automatic logic [15:0] y_of(input logic [7:0] a, input logic [7:0] b, input logic zm);
        int prod;
        prod = int'(a) * int'(b);
        if (zm) return 16'd0;
        case (a[7:6])
            2'd0:    return 16'(prod);
            2'd1:    return 16'd0;
            2'd2:    return 16'(prod) ^ 16'h0001;
            default: return 16'(prod + int'(a[3:0] ^ b[3:0]));
        endcase
    endfunction

    always_comb y_in = y_of(a_out, b_out, zero_mode);

    function automatic exp_t compute_expected(input int drive_cyc, input logic zm);
        exp_t e;
        int   ed;
        e.err = 0;
        e.sum = 0;
        e.mx  = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ed = int'(y_of(8'(a), 8'(b), zm)) - a * b;
                if (ed < 0) ed = -ed;
                if (ed != 0) e.err++;
                e.sum += longint'(ed);
                if (longint'(ed) > e.mx) e.mx = longint'(ed);
            end
        end
`ifndef AXRM_MAXED_EN
        e.mx = 0;
`endif
        e.done_cyc = longint'(drive_cyc) + 65538;
        return e;
    endfunction

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic drive_start();
        start = 1'b1;
        sb_q.push_back(compute_expected(cyc, zero_mode));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Operand sequence and busy-length monitor.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
            if (pair_idx < 65536) begin
                if ({a_out, b_out} !== 16'(pair_idx)) pair_err++;
                pair_idx++;
            end
        end else begin
            if (busy_prev) last_busy_len = busy_cnt;
            busy_cnt = 0;
            pair_idx = 0;
        end
        busy_prev = (busy === 1'b1);
    end

    initial begin
        exp_t   e;
        longint p_err;
        longint p_sum;
        bit     seen;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_a", a_out, 0);
        check_eq("rst_b", b_out, 0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_sum", sum_ed, 0);
        check_eq("rst_max", max_ed, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);

        // Sweep A: stuck-at-zero multiplier, aborted by reset mid-run.
        zero_mode = 1'b1;
        drive_start();
        check_eq("run_busy", busy, 1);
        check_eq("run_done", done, 0);
        repeat (1000) @(negedge clk);
        check_eq("run_a1000", a_out, 3);
        check_eq("run_b1000", b_out, 232);
        p_err = 0;
        p_sum = 0;
        for (int i = 0; i < 999; i++) begin
            if ((i / 256) * (i % 256) != 0) p_err++;
            p_sum += longint'((i / 256) * (i % 256));
        end
        check_eq("run_err_partial", err_count, p_err);
        check_eq("run_sum_partial", sum_ed, p_sum);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_a", a_out, 0);
        check_eq("abort_b", b_out, 0);
        check_eq("abort_err", err_count, 0);
        check_eq("abort_sum", sum_ed, 0);
        check_eq("abort_max", max_ed, 0);
        sb_q.delete();
        $display("sweep aborted by reset at RUN cycle 1000");

        start = 1'b1;
        @(negedge clk);
        check_eq("rst_over_start", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_after_rst", busy, 0);

        // Sweep B: mixed-error multiplier, with an ignored start pulse mid-run.
        zero_mode = 1'b0;
        drive_start();
        seen = 1'b0;
        for (int n = 1; n <= 70000 && !seen; n++) begin
            start = (n == 500);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;

        if (!seen) begin
            check_eq("done_timeout", 0, 1);
        end else if (sb_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            $display("sweep done at cycle %0d err_count=%0d sum_ed=%0d max_ed=%0d",
                     cyc, err_count, sum_ed, max_ed);
            check_eq("done_cycle", cyc, e.done_cyc);
            check_eq("sweep_err", err_count, e.err);
            check_eq("sweep_sum", sum_ed, e.sum);
            check_eq("sweep_max", max_ed, e.mx);
            check_eq("done_busy", busy, 0);
            #1;
            check_eq("busy_len", last_busy_len, 65537);
            check_eq("pair_seq_errors", pair_err, 0);

            repeat (5) @(negedge clk);
            check_eq("hold_done", done, 1);
            check_eq("hold_err", err_count, e.err);
            check_eq("hold_sum", sum_ed, e.sum);
            check_eq("hold_max", max_ed, e.mx);
            check_eq("hold_a", a_out, 255);
            check_eq("hold_b", b_out, 255);

            // Restart from DONE clears statistics, then reset aborts it.
            drive_start();
            $display("restart from DONE at cycle %0d", cyc);
            check_eq("restart_busy", busy, 1);
            check_eq("restart_done", done, 0);
            check_eq("restart_err", err_count, 0);
            check_eq("restart_sum", sum_ed, 0);
            check_eq("restart_max", max_ed, 0);
            rst = 1'b1;
            @(negedge clk);
            check_eq("final_rst_busy", busy, 0);
            rst = 1'b0;
            sb_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
